// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - access size encodings and dump FSM state type for the byte-lane data memory
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } dump_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = byte_off[0];
            SZ_WORD: is_misaligned = (byte_off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// rtl/dm_load_align.sv - lane select with sign/zero extension; also yields the lane mask for store merging
module dm_load_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_ld_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    output logic [31:0] load_data_o,
    output logic [3:0]  lane_mask_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = word_i >> {byte_off_i, 3'b000};
        misaligned_o = is_misaligned(size_i, byte_off_i);
        load_data_o  = 32'h0;
        lane_mask_o  = 4'b0000;
        case (size_i)
            SZ_BYTE: begin
                lane_mask_o = 4'b0001 << byte_off_i;
                load_data_o = unsigned_ld_i ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                lane_mask_o = 4'b0011 << byte_off_i;
                load_data_o = unsigned_ld_i ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                lane_mask_o = 4'b1111;
                load_data_o = word_i;
            end
            default: begin
                lane_mask_o = 4'b0000;
                load_data_o = 32'h0;
            end
        endcase
        // An illegal access must neither touch any lane nor return data.
        if (misaligned_o) begin
            lane_mask_o = 4'b0000;
            load_data_o = 32'h0;
        end
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// rtl/data_memory_bytelane.sv - byte-addressable data memory with written tracking and a streaming dump FSM
module data_memory_bytelane
    import data_memory_pkg::*;
#(
    parameter int WORD_ADDR_W = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [1:0]               size,
    input  logic                     unsigned_ld,
    input  logic [WORD_ADDR_W+1:0]   address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     misaligned,
    input  logic                     eof,
    output logic                     busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [WORD_ADDR_W-1:0]   dump_addr,
    output logic [31:0]              dump_data,
    output logic                     dump_done
);

    localparam int DEPTH = 1 << WORD_ADDR_W;
    localparam logic [WORD_ADDR_W-1:0] LAST_IDX = {WORD_ADDR_W{1'b1}};

    logic [31:0]            mem_q [DEPTH];
    logic [DEPTH-1:0]       written_q;

    dump_state_e            state_q;
    logic [WORD_ADDR_W-1:0] idx_q;
    logic                   eof_q;
    logic                   eof_rise_q;
    logic                   dump_valid_q;
    logic [WORD_ADDR_W-1:0] dump_addr_q;
    logic [31:0]            dump_data_q;
    logic                   dump_done_q;

    logic [WORD_ADDR_W-1:0] widx;
    logic [31:0]            cur_word;
    logic                   cur_written;
    logic [31:0]            load_word;
    logic [3:0]             lane_mask;
    logic                   mis_raw;
    logic [31:0]            store_data;
    logic [31:0]            merged_d;
    logic                   store_en;

    assign widx        = address[WORD_ADDR_W+1:2];
    assign cur_word    = mem_q[widx];
    assign cur_written = written_q[widx];

    dm_load_align u_align (
        .size_i        (size),
        .unsigned_ld_i (unsigned_ld),
        .byte_off_i    (address[1:0]),
        .word_i        (cur_word),
        .load_data_o   (load_word),
        .lane_mask_o   (lane_mask),
        .misaligned_o  (mis_raw)
    );

    assign misaligned = (mem_read | mem_write) & mis_raw;
    assign read_data  = (mem_read && !mis_raw && cur_written) ? load_word : 32'h0;
    assign busy       = (state_q != ST_IDLE);
    assign store_en   = mem_write && !mis_raw && !busy && !reset;

    always_comb begin
        case (size)
            SZ_BYTE: store_data = {4{write_data[7:0]}};
            SZ_HALF: store_data = {2{write_data[15:0]}};
            default: store_data = write_data;
        endcase
        merged_d = 32'h0;
        // Untouched lanes of a never-written word are zeroed so contents stay deterministic.
        for (int k = 0; k < 4; k++) begin
            merged_d[8*k +: 8] = lane_mask[k] ? store_data[8*k +: 8]
                               : (cur_written ? cur_word[8*k +: 8] : 8'h00);
        end
    end

    always_ff @(posedge clock) begin
        if (store_en) begin
            mem_q[widx] <= merged_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            written_q <= '0;
        end else if (store_en) begin
            written_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            // Tracking eof through reset keeps a level held across release from looking like an edge.
            eof_q        <= eof;
            eof_rise_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= 32'h0;
            dump_done_q  <= 1'b0;
        end else begin
            eof_q      <= eof;
            eof_rise_q <= eof & ~eof_q;
            case (state_q)
                ST_IDLE: begin
                    if (eof_rise_q) begin
                        state_q <= ST_SCAN;
                        idx_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (written_q[idx_q]) begin
                        state_q      <= ST_EMIT;
                        dump_valid_q <= 1'b1;
                        dump_addr_q  <= idx_q;
                        dump_data_q  <= mem_q[idx_q];
                    end else if (idx_q == LAST_IDX) begin
                        state_q     <= ST_DONE;
                        dump_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q     <= ST_DONE;
                            dump_done_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb/tb_data_memory_bytelane.sv - directed vector table plus dump-sequence checks for data_memory_bytelane
module tb_data_memory_bytelane;

    localparam int W = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [1:0]    size = 2'b10;
    logic          unsigned_ld = 1'b0;
    logic [W+1:0]  address = '0;
    logic [31:0]   write_data = '0;
    logic [31:0]   read_data;
    logic          misaligned;
    logic          eof = 1'b0;
    logic          busy;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [W-1:0]  dump_addr;
    logic [31:0]   dump_data;
    logic          dump_done;

    int vectors = 0;
    int miscompares = 0;

    data_memory_bytelane #(.WORD_ADDR_W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .misaligned  (misaligned),
        .eof         (eof),
        .busy        (busy),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .dump_done   (dump_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [5:0] a, input logic [31:0] wd, input logic [31:0] er,
                                input logic em);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns;
        v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_mis = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [31:0] d);
        @(negedge clock);
        mem_write = 1'b1; size = 2'b10; address = a; write_data = d;
        @(posedge clock);
        #1 mem_write = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        @(negedge clock);
        mem_read = 1'b1; size = 2'b10; unsigned_ld = 1'b0; address = a;
        #1 check(name, read_data, exp);
        mem_read = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        while (!dump_valid && cycles < 60) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
        end
        if (!dump_valid) check({name, "_timeout"}, 32'(dump_valid), 32'd1);
    endtask

    task automatic pulse_eof();
        @(negedge clock);
        eof = 1'b1;
        @(negedge clock);
        eof = 1'b0;
    endtask

    logic [3:0]  exp_addr [3];
    logic [31:0] exp_data [3];
    int cyc;
    int scan_cycles;
    logic seen_valid;

    initial begin
        vecs.push_back(mk(0, 1, 2'b10, 0, 6'h10, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 6'h10, 32'h0, 32'hFFFFFFEF, 0));
        vecs.push_back(mk(1, 0, 2'b00, 1, 6'h13, 32'h0, 32'h000000DE, 0));
        vecs.push_back(mk(1, 0, 2'b01, 0, 6'h12, 32'h0, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(1, 0, 2'b01, 1, 6'h10, 32'h0, 32'h0000BEEF, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 6'h11, 32'h0, 32'hFFFFFFBE, 0));
        vecs.push_back(mk(1, 0, 2'b10, 1, 6'h10, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 2'b00, 0, 6'h21, 32'h0000007F, 32'h0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h20, 32'h0, 32'h00007F00, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 6'h22, 32'h00001234, 32'h0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h20, 32'h0, 32'h12347F00, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 6'h04, 32'hCAFEF00D, 32'h0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 6'h05, 32'h00005555, 32'h0, 1));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h06, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 2'b11, 0, 6'h04, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 2'b11, 0, 6'h04, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h04, 32'h0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h08, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 2'b11, 0, 6'h05, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 2'b10, 0, 6'h10, 32'h11111111, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h10, 32'h0, 32'h11111111, 0));
        vecs.push_back(mk(0, 1, 2'b00, 0, 6'h2D, 32'hFFFFFF80, 32'h0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 6'h2C, 32'h0, 32'h00008000, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 6'h2D, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(1, 0, 2'b00, 1, 6'h2D, 32'h0, 32'h00000080, 0));

        do_reset();
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_addr", 32'(dump_addr), 32'd0);
        check("rst_data", dump_data, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clock);
            mem_read = vecs[i].rd; mem_write = vecs[i].wr; size = vecs[i].sz;
            unsigned_ld = vecs[i].uns; address = vecs[i].addr; write_data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_mis", i), 32'(misaligned), 32'(vecs[i].exp_mis));
        end
        @(negedge clock);
        mem_read = 1'b0; mem_write = 1'b0;

        // Dump of words 0, 7, 15 with a stalled first beat and a store attempted while busy.
        do_reset();
        read_check("post_rst_cleared", 6'h10, 32'h0);
        exp_addr[0] = 4'd0;  exp_data[0] = 32'hA0A0A0A0;
        exp_addr[1] = 4'd7;  exp_data[1] = 32'h77770007;
        exp_addr[2] = 4'd15; exp_data[2] = 32'hF0F0F00F;
        for (int b = 0; b < 3; b++) write_word({exp_addr[b], 2'b00}, exp_data[b]);

        @(negedge clock);
        eof = 1'b1;
        wait_valid("first_beat", cyc);
        eof = 1'b0;
        vectors++;
        if (cyc < 3) begin
            miscompares++;
            $display("FAIL first_beat_latency: got %0d edges expected at least 3", cyc);
        end
        for (int b = 0; b < 3; b++) begin
            if (b > 0) wait_valid($sformatf("beat%0d", b), cyc);
            check($sformatf("beat%0d_addr", b), 32'(dump_addr), 32'(exp_addr[b]));
            check($sformatf("beat%0d_data", b), dump_data, exp_data[b]);
            if (b == 0) begin
                mem_write = 1'b1; size = 2'b10; address = 6'h00; write_data = 32'h55555555;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clock);
                    mem_write = 1'b0;
                    check($sformatf("stall%0d_valid", s), 32'(dump_valid), 32'd1);
                    check($sformatf("stall%0d_addr", s), 32'(dump_addr), 32'(exp_addr[0]));
                    check($sformatf("stall%0d_data", s), dump_data, exp_data[0]);
                end
            end
            dump_ready = 1'b1;
            @(posedge clock);
            #1 dump_ready = 1'b0;
        end
        cyc = 0;
        while (!dump_done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check("dump_done", 32'(dump_done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        read_check("busy_store_dropped", 6'h00, 32'hA0A0A0A0);
        pulse_eof();
        repeat (4) @(negedge clock);
        check("done_ignores_eof_valid", 32'(dump_valid), 32'd0);
        check("done_sticky", 32'(dump_done), 32'd1);

        // Reset during the second beat, then an empty dump.
        do_reset();
        write_word(6'h00, 32'h00000001);
        write_word(6'h1C, 32'h00000007);
        pulse_eof();
        wait_valid("b_first", cyc);
        dump_ready = 1'b1;
        @(posedge clock);
        #1 dump_ready = 1'b0;
        @(negedge clock);
        wait_valid("b_second", cyc);
        check("b_second_addr", 32'(dump_addr), 32'd7);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_valid", 32'(dump_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        read_check("midrst_written_clear", 6'h1C, 32'h0);

        @(negedge clock);
        eof = 1'b1;
        scan_cycles = 0;
        seen_valid = 1'b0;
        cyc = 0;
        while (!dump_done && cyc < 60) begin
            @(negedge clock);
            eof = 1'b0;
            cyc++;
            if (dump_valid) seen_valid = 1'b1;
            if (busy && !dump_done) scan_cycles++;
        end
        check("empty_done", 32'(dump_done), 32'd1);
        check("empty_no_beats", 32'(seen_valid), 32'd0);
        check("empty_scan_cycles", 32'(scan_cycles), 32'd16);

        // eof held high across reset release must not start a dump.
        @(negedge clock);
        reset = 1'b1; eof = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("eof_thru_rst_busy", 32'(busy), 32'd0);
        check("eof_thru_rst_done", 32'(dump_done), 32'd0);
        eof = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
